// File: rtl/hazard_pkg.sv
// Shared constants and the forwarding-select helper for the pipeline hazard unit.
package hazard_pkg;

    localparam logic [1:0] FW_RF  = 2'b00;
    localparam logic [1:0] FW_WB  = 2'b01;
    localparam logic [1:0] FW_MEM = 2'b10;

    localparam logic [1:0] WB_SEL_LOAD = 2'b01;

    // Memory-stage result is younger than Writeback, so it is checked first.
    function automatic logic [1:0] fw_select(
        input logic       wen_m,
        input logic [4:0] rd_m,
        input logic       wen_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = FW_RF;
        if (wen_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FW_MEM;
        end else if (wen_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FW_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and branch flush control for a 5-stage pipeline.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic [1:0]       writebackE,
    input  logic             wen_rfM,
    input  logic             wen_rfW,
    input  logic             en_branch,
    output logic [1:0]       fw_AE,
    output logic [1:0]       fw_BE,
    output logic             STALLPCF,
    output logic             STALLD,
    output logic             FLUSHD,
    output logic             FLUSHE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic       lwstall;
    logic [1:0] perf_evt;

    assign fw_AE = fw_select(wen_rfM, rdM, wen_rfW, rdW, rs1E);
    assign fw_BE = fw_select(wen_rfM, rdM, wen_rfW, rdW, rs2E);

    // A load in Execute cannot forward to Decode in time; hold Fetch/Decode one cycle.
    assign lwstall = (writebackE == WB_SEL_LOAD) && (rdE != 5'd0)
                  && ((rdE == rs1D) || (rdE == rs2D));

    assign STALLPCF = lwstall;
    assign STALLD   = lwstall;
    assign FLUSHD   = en_branch;
    assign FLUSHE   = lwstall | en_branch;

    assign perf_evt = {FLUSHD | FLUSHE, lwstall};

`ifdef HAZARD_PERF_CNT_EN
    logic [1:0][CNT_W-1:0] perf_cnt;
    genvar gi;

    for (gi = 0; gi < 2; gi++) begin : g_cnt
        hazard_perf_cnt #(
            .W(CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (perf_evt[gi]),
            .cnt_o (perf_cnt[gi])
        );
    end

    assign stall_cnt = perf_cnt[0];
    assign flush_cnt = perf_cnt[1];
`else
    logic unused_perf;

    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign unused_perf = &{1'b0, clk, rst_n, perf_evt};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_unit;

    localparam int CNT_W = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0]       writebackE;
    logic             wen_rfM, wen_rfW, en_branch;
    logic [1:0]       fw_AE, fw_BE;
    logic             STALLPCF, STALLD, FLUSHD, FLUSHE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .rdM        (rdM),
        .rdW        (rdW),
        .writebackE (writebackE),
        .wen_rfM    (wen_rfM),
        .wen_rfW    (wen_rfW),
        .en_branch  (en_branch),
        .fw_AE      (fw_AE),
        .fw_BE      (fw_BE),
        .STALLPCF   (STALLPCF),
        .STALLD     (STALLD),
        .FLUSHD     (FLUSHD),
        .FLUSHE     (FLUSHE),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clr_inputs();
        rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
        rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
        writebackE = 2'b00;
        wen_rfM = 1'b0; wen_rfW = 1'b0; en_branch = 1'b0;
    endtask

    function automatic logic [31:0] ctrl();
        return {28'd0, STALLPCF, STALLD, FLUSHD, FLUSHE};
    endfunction

    function automatic logic [31:0] exp_cnt(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        #1;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        // Combinational paths must work while reset is held.
        rs1E = 5'd3; rdM = 5'd3; wen_rfM = 1'b1; en_branch = 1'b1;
        #1;
        chk("rst_fw_AE", 32'(fw_AE), 32'd2);
        chk("rst_ctrl", ctrl(), 32'b0011);
        clr_inputs();

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_fw_AE", 32'(fw_AE), 32'd0);
        chk("idle_fw_BE", 32'(fw_BE), 32'd0);
        chk("idle_ctrl", ctrl(), 32'b0000);

        rs1E = 5'd10; rdM = 5'd10; wen_rfM = 1'b1; #1;
        chk("mem_fw_AE", 32'(fw_AE), 32'd2);
        chk("mem_fw_BE", 32'(fw_BE), 32'd0);
        rdM = 5'd0; #1;
        chk("rdM0_fw_AE", 32'(fw_AE), 32'd0);
        rdM = 5'd10; wen_rfM = 1'b0; #1;
        chk("wenM0_fw_AE", 32'(fw_AE), 32'd0);
        wen_rfM = 1'b1;

        rs2E = 5'd20; rdW = 5'd20; wen_rfW = 1'b1; #1;
        chk("wb_fw_BE", 32'(fw_BE), 32'd1);
        chk("wb_fw_AE", 32'(fw_AE), 32'd2);
        rdW = 5'd0; #1;
        chk("rdW0_fw_BE", 32'(fw_BE), 32'd0);
        rdW = 5'd20; wen_rfW = 1'b0; #1;
        chk("wenW0_fw_BE", 32'(fw_BE), 32'd0);
        wen_rfW = 1'b1; rs1E = 5'd20; #1;
        chk("wbA_fw_AE", 32'(fw_AE), 32'd1);

        clr_inputs();
        rs1E = 5'd7; rs2E = 5'd7; rdM = 5'd7; rdW = 5'd7;
        wen_rfM = 1'b1; wen_rfW = 1'b1; #1;
        chk("prio_fw_AE", 32'(fw_AE), 32'd2);
        chk("prio_fw_BE", 32'(fw_BE), 32'd2);

        clr_inputs();
        rs1D = 5'd5; rdE = 5'd5; writebackE = 2'b01; #1;
        chk("lw_rs1_ctrl", ctrl(), 32'b1101);
        en_branch = 1'b1; #1;
        chk("lw_br_ctrl", ctrl(), 32'b1111);
        clr_inputs();
        rs2D = 5'd9; rdE = 5'd9; writebackE = 2'b01; #1;
        chk("lw_rs2_ctrl", ctrl(), 32'b1101);
        writebackE = 2'b10; #1;
        chk("nonload_ctrl", ctrl(), 32'b0000);
        writebackE = 2'b01; rdE = 5'd0; rs2D = 5'd0; #1;
        chk("rdE0_ctrl", ctrl(), 32'b0000);
        clr_inputs();
        en_branch = 1'b1; #1;
        chk("br_ctrl", ctrl(), 32'b0011);

        // Counter windows start from a freshly cleared state.
        @(negedge clk);
        clr_inputs();
        rs1D = 5'd5; rdE = 5'd5; writebackE = 2'b01; en_branch = 1'b1;
        rst_n = 1'b0; #1;
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("A_stall_cnt", 32'(stall_cnt), exp_cnt(3));
        chk("A_flush_cnt", 32'(flush_cnt), exp_cnt(3));

        writebackE = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("B_stall_cnt", 32'(stall_cnt), exp_cnt(3));
        chk("B_flush_cnt", 32'(flush_cnt), exp_cnt(5));

        clr_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("C_stall_cnt", 32'(stall_cnt), exp_cnt(3));
        chk("C_flush_cnt", 32'(flush_cnt), exp_cnt(5));

        rs1D = 5'd5; rdE = 5'd5; writebackE = 2'b01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sat_stall_cnt", 32'(stall_cnt), exp_cnt(7));
        chk("sat_flush_cnt", 32'(flush_cnt), exp_cnt(7));

        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
        chk("mid_rst_flush", 32'(flush_cnt), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("resume_stall", 32'(stall_cnt), exp_cnt(1));
        chk("resume_flush", 32'(flush_cnt), exp_cnt(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter CNT_W, default 32, width of the performance counters.
REQ-002 clk  input  1  clock; all sequential state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rs1D, rs2D  input  5 each  source register indices of the instruction in Decode.
REQ-005 rs1E, rs2E  input  5 each  source register indices of the instruction in Execute.
REQ-006 rdE, rdM, rdW  input  5 each  destination register indices in Execute, Memory and Writeback.
REQ-007 writebackE  input  2  result-source select in Execute; 2'b01 marks a load.
REQ-008 wen_rfM, wen_rfW  input  1 each  register-file write enable in Memory and Writeback.
REQ-009 en_branch  input  1  taken branch or jump resolved in Execute.
REQ-010 fw_AE, fw_BE  output  2 each  forwarding select for ALU operands A and B.
REQ-011 STALLPCF, STALLD  output  1 each  hold the PC register and the Fetch/Decode register.
REQ-012 FLUSHD, FLUSHE  output  1 each  clear the Fetch/Decode and Decode/Execute registers.
REQ-013 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-014 fw_AE SHALL be 2'b10 when wen_rfM=1, rdM!=0 and rdM==rs1E.
REQ-015 Otherwise, fw_AE SHALL be 2'b01 when wen_rfW=1, rdW!=0 and rdW==rs1E.
REQ-016 Otherwise, fw_AE SHALL be 2'b00.
REQ-017 fw_BE SHALL follow REQ-014..016 with rs2E in place of rs1E.
REQ-018 Memory-stage forwarding SHALL take priority over Writeback when both match.
REQ-019 lwstall SHALL be 1 when writebackE==2'b01, rdE!=0, and (rdE==rs1D or rdE==rs2D).
REQ-020 STALLPCF and STALLD SHALL both equal lwstall.
REQ-021 FLUSHD SHALL equal en_branch.
REQ-022 FLUSHE SHALL equal lwstall OR en_branch.
REQ-023 When lwstall and en_branch are both set, all four control outputs SHALL be 1.
REQ-024 fw_AE, fw_BE, STALLPCF, STALLD, FLUSHD and FLUSHE SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst_n.
REQ-025 stall_cnt SHALL increment by 1 on each rising clk edge where lwstall=1.
REQ-026 flush_cnt SHALL increment by 1 on each rising clk edge where FLUSHD=1 or FLUSHE=1.
REQ-027 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-028 While rst_n=0, stall_cnt and flush_cnt SHALL be 0 immediately, independent of clk.
REQ-029 Combinational outputs SHALL be unaffected by reset.
REQ-030 Counting SHALL resume on the first rising clk edge after rst_n returns to 1.
REQ-031 Asserting rst_n=0 mid-operation SHALL clear both counters regardless of pending events.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN SHALL select whether the performance counters are built.
REQ-033 With HAZARD_PERF_CNT_EN defined, REQ-025..027 SHALL apply.
REQ-034 Without HAZARD_PERF_CNT_EN, no counter flops SHALL be built and stall_cnt and flush_cnt SHALL be constant 0.
REQ-035 The port list SHALL be identical with and without HAZARD_PERF_CNT_EN.

Structure
REQ-036 Package hazard_pkg SHALL hold the forwarding-select constants FW_RF=2'b00, FW_WB=2'b01 and FW_MEM=2'b10.
REQ-037 hazard_pkg SHALL also hold the result-source constant WB_SEL_LOAD=2'b01.
REQ-038 The saturating counter SHALL be one sub-module, hazard_perf_cnt, instantiated twice.
REQ-039 All forwarding, stall and flush logic SHALL be in the top module.

Verification
REQ-040 Idle (all inputs 0) -> fw_AE=fw_BE=00, all stall/flush outputs 0.
REQ-041 rs1E=10, rdM=10, wen_rfM=1 -> fw_AE=10; same with rdM=0 -> fw_AE=00.
REQ-042 Add rs2E=20, rdW=20, wen_rfW=1 -> fw_BE=01, fw_AE stays 10.
REQ-043 rs1E=rs2E=7, rdM=rdW=7, wen_rfM=wen_rfW=1 -> fw_AE=fw_BE=10 (Memory stage wins).
REQ-044 rs1D=5, rdE=5, writebackE=01 -> STALLPCF=STALLD=FLUSHE=1, FLUSHD=0; add en_branch=1 -> FLUSHD=1; with HAZARD_PERF_CNT_EN, after 3 clocks stall_cnt=3 and flush_cnt=3.
REQ-045 With HAZARD_PERF_CNT_EN, counters non-zero, pulse rst_n=0 between clock edges -> both counters read 0 immediately.
